pool: RTL and testbench

Max-pooling stage between the normalization block and the BRAM C write interface. It consumes the row stream the normalization stage produces (one row of `MAT_MUL_SIZE` signed lanes per valid cycle) and reduces it over a 1×1, 2×2 or 4×4 window, selected at burst start. Its output row stream and valid strobe feed the output-BRAM write flop stage in `top`. It also drives `done_pool` to the control block.

---
 rtl/pool.sv | 188 ++++++++++++++++++
 tb/tb_pool.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pool.sv
// ---------------------------------------------------------------------------
// pool
// Max-pooling stage placed between the normalization block and the output
// BRAM write path. Each accepted input row (MAT_MUL_SIZE signed lanes) is
// first reduced horizontally over W adjacent lanes. The result is then reduced
// vertically over W consecutive rows. W is 1, 2 or 4 and is latched at burst
// start.
//
// Ports
//   clk                 : clock
//   resetn              : asynchronous active-low reset
//   enable_pool         : 0 forces bypass (W = 1)
//   pool_window         : 0/3 bypass, 1 = 2x2, 2 = 4x4
//   in_data_available   : input row valid, no backpressure
//   inp_data            : input row, lane i at [i*DWIDTH +: DWIDTH]
//   out_data            : registered pooled row, holds when not strobed
//   out_data_available  : one-cycle strobe per output row
//   done_pool           : high when idle with nothing held
// ---------------------------------------------------------------------------
module pool #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           enable_pool,
    input  logic [1:0]                     pool_window,
    input  logic                           in_data_available,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
    output logic                           out_data_available,
    output logic                           done_pool
);

    localparam int ROW_W = MAT_MUL_SIZE * DWIDTH;

    typedef enum logic [1:0] {IDLE, BYPASS, ACC, FLUSH} state_t;

    function automatic logic signed [DWIDTH-1:0] smax(
        input logic signed [DWIDTH-1:0] a,
        input logic signed [DWIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Window width is carried as W-1 (0, 1 or 3) so it fits the 2-bit counter.
    // Output lanes that have no complete group of W input lanes are zero.
    function automatic logic [ROW_W-1:0] h_reduce(
        input logic [ROW_W-1:0] row,
        input logic [1:0]       wm1
    );
        logic [ROW_W-1:0]          r;
        logic signed [DWIDTH-1:0] m;
        int                        w;
        r = '0;
        w = int'(wm1) + 1;
        for (int j = 0; j < MAT_MUL_SIZE; j++) begin
            if ((j + 1) * w <= MAT_MUL_SIZE) begin
                m = row[j*w*DWIDTH +: DWIDTH];
                for (int k = 1; k < 4; k++) begin
                    if (k < w) m = smax(m, row[(j*w+k)*DWIDTH +: DWIDTH]);
                end
                r[j*DWIDTH +: DWIDTH] = m;
            end
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] v_max(
        input logic [ROW_W-1:0] a,
        input logic [ROW_W-1:0] b
    );
        logic [ROW_W-1:0] r;
        for (int j = 0; j < MAT_MUL_SIZE; j++)
            r[j*DWIDTH +: DWIDTH] = smax(a[j*DWIDTH +: DWIDTH], b[j*DWIDTH +: DWIDTH]);
        return r;
    endfunction

    state_t           state, state_nxt;
    logic [1:0]       wm1_p1, wm1_nxt;
    logic [1:0]       cnt_p1, cnt_nxt;
    logic [ROW_W-1:0] run_max_p1, run_max_nxt;
    logic [ROW_W-1:0] out_row_p1, out_row_nxt;
    logic             vld_p1, vld_nxt;
    logic [1:0]       mode_wm1;
    logic [ROW_W-1:0] row_h_p0;
    logic [ROW_W-1:0] acc_row;

    always_comb begin
        mode_wm1 = 2'd0;
        if (enable_pool) begin
            case (pool_window)
                2'd1:    mode_wm1 = 2'd1;
                2'd2:    mode_wm1 = 2'd3;
                default: mode_wm1 = 2'd0;
            endcase
        end
    end

    // ---- stage p0: horizontal reduction of the incoming row ----
    // Inside a window the latched width applies; at burst start the live mode does.
    assign row_h_p0 = h_reduce(inp_data, (state == ACC) ? wm1_p1 : mode_wm1);

    always_comb begin
        state_nxt   = state;
        wm1_nxt     = wm1_p1;
        cnt_nxt     = cnt_p1;
        run_max_nxt = run_max_p1;
        out_row_nxt = out_row_p1;
        vld_nxt     = 1'b0;
        acc_row     = row_h_p0;
        case (state)
            // FLUSH accepts a new burst exactly like IDLE, so a flush and the
            // next burst's first row can land on adjacent edges.
            IDLE, FLUSH: begin
                state_nxt = IDLE;
                if (in_data_available) begin
                    wm1_nxt = mode_wm1;
                    if (mode_wm1 == 2'd0) begin
                        out_row_nxt = inp_data;
                        vld_nxt     = 1'b1;
                        state_nxt   = BYPASS;
                    end else begin
                        run_max_nxt = row_h_p0;
                        cnt_nxt     = 2'd0;
                        state_nxt   = ACC;
                    end
                end
            end
            BYPASS: begin
                if (in_data_available) begin
                    out_row_nxt = inp_data;
                    vld_nxt     = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACC: begin
                // cnt_p1 == wm1_p1 means the previous window just completed.
                if (in_data_available) begin
                    if (cnt_p1 == wm1_p1) begin
                        acc_row = row_h_p0;
                        cnt_nxt = 2'd0;
                    end else begin
                        acc_row = v_max(run_max_p1, row_h_p0);
                        cnt_nxt = cnt_p1 + 2'd1;
                    end
                    run_max_nxt = acc_row;
                    if (cnt_nxt == wm1_p1) begin
                        out_row_nxt = acc_row;
                        vld_nxt     = 1'b1;
                    end
                end else if (cnt_p1 == wm1_p1) begin
                    state_nxt = IDLE;
                end else begin
                    out_row_nxt = run_max_p1;
                    vld_nxt     = 1'b1;
                    state_nxt   = FLUSH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p1: window state, running max and output register ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            wm1_p1     <= 2'd0;
            cnt_p1     <= 2'd0;
            run_max_p1 <= '0;
            out_row_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wm1_p1     <= wm1_nxt;
            cnt_p1     <= cnt_nxt;
            run_max_p1 <= run_max_nxt;
            out_row_p1 <= out_row_nxt;
            vld_p1     <= vld_nxt;
        end
    end

    assign out_data           = out_row_p1;
    assign out_data_available = vld_p1;
    assign done_pool          = (state == IDLE);

endmodule

// File: tb/tb_pool.sv
module tb_pool;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable_pool;
    logic [1:0]  pool_window;
    logic        in_data_available;
    logic [31:0] inp_data;
    logic [31:0] out_data;
    logic        out_data_available;
    logic        done_pool;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pool #(.DWIDTH(8), .MAT_MUL_SIZE(4)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .enable_pool        (enable_pool),
        .pool_window        (pool_window),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_pool          (done_pool)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] row4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present inputs for the current cycle, then move to just after the next edge.
    task automatic drive(input logic v, input logic [31:0] r);
        in_data_available = v;
        inp_data          = r;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected row.
    always @(negedge clk) begin
        if (out_data_available === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got %h expected no output", out_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_row: got %h expected %h", out_data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1, r2, r3, r4, m;
        r1 = row4(1, -5, 7, 3);
        r2 = row4(4, 2, -1, 9);
        r3 = row4(-3, -8, 5, 6);
        r4 = row4(10, -20, -30, -40);
        m  = row4(-100, -100, -100, -100);

        resetn = 1'b0; enable_pool = 1'b0; pool_window = 2'd0;
        in_data_available = 1'b0; inp_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_vld", {31'b0, out_data_available}, 32'h0);
        chk("reset_done", {31'b0, done_pool}, 32'h1);
        resetn = 1'b1;
        drive(1'b0, '0);

        // bypass
        enable_pool = 1'b0;
        exp_q.push_back(row4(1, 2, 3, 4));
        drive(1'b1, row4(1, 2, 3, 4));
        chk("bypass_latency", {31'b0, out_data_available}, 32'h1);
        chk("bypass_done_low", {31'b0, done_pool}, 32'h0);
        drive(1'b0, '0);
        chk("bypass_single_strobe", {31'b0, out_data_available}, 32'h0);
        chk("bypass_done_high", {31'b0, done_pool}, 32'h1);
        chk("out_hold", out_data, row4(1, 2, 3, 4));

        // 2x2 single window
        enable_pool = 1'b1; pool_window = 2'd1;
        exp_q.push_back(row4(4, 9, 0, 0));
        drive(1'b1, r1);
        chk("p2_no_early", {31'b0, out_data_available}, 32'h0);
        drive(1'b1, r2);
        chk("p2_latency", {31'b0, out_data_available}, 32'h1);
        chk("p2_done_low", {31'b0, done_pool}, 32'h0);
        drive(1'b0, '0);
        chk("p2_done_high", {31'b0, done_pool}, 32'h1);

        // 2x2 with odd row flushed
        exp_q.push_back(row4(4, 9, 0, 0));
        exp_q.push_back(row4(-3, 6, 0, 0));
        drive(1'b1, r1);
        drive(1'b1, r2);
        drive(1'b1, r3);
        chk("flush_no_early", {31'b0, out_data_available}, 32'h0);
        drive(1'b0, '0);
        chk("flush_latency", {31'b0, out_data_available}, 32'h1);
        chk("flush_done_low", {31'b0, done_pool}, 32'h0);
        drive(1'b0, '0);
        chk("flush_done_high", {31'b0, done_pool}, 32'h1);

        // 4x4
        pool_window = 2'd2;
        exp_q.push_back(row4(-7, 0, 0, 0));
        drive(1'b1, m);
        drive(1'b1, m);
        drive(1'b1, row4(-100, -100, -7, -100));
        chk("p4_no_early", {31'b0, out_data_available}, 32'h0);
        drive(1'b1, m);
        chk("p4_latency", {31'b0, out_data_available}, 32'h1);
        drive(1'b0, '0);
        chk("p4_done_high", {31'b0, done_pool}, 32'h1);

        // mode latched at burst start
        pool_window = 2'd1;
        exp_q.push_back(row4(4, 9, 0, 0));
        drive(1'b1, r1);
        pool_window = 2'd0; enable_pool = 1'b0;
        drive(1'b1, r2);
        chk("latch_latency", {31'b0, out_data_available}, 32'h1);
        drive(1'b0, '0);

        // back-to-back 2x2 windows
        enable_pool = 1'b1; pool_window = 2'd1;
        exp_q.push_back(row4(4, 9, 0, 0));
        exp_q.push_back(row4(10, 6, 0, 0));
        drive(1'b1, r1);
        drive(1'b1, r2);
        drive(1'b1, r3);
        drive(1'b1, r4);
        chk("b2b_second", {31'b0, out_data_available}, 32'h1);
        drive(1'b0, '0);

        // flush followed immediately by a new bypass burst
        exp_q.push_back(row4(4, 9, 0, 0));
        exp_q.push_back(row4(-3, 6, 0, 0));
        exp_q.push_back(row4(5, 6, 7, 8));
        drive(1'b1, r1);
        drive(1'b1, r2);
        drive(1'b1, r3);
        drive(1'b0, '0);
        enable_pool = 1'b0;
        drive(1'b1, row4(5, 6, 7, 8));
        chk("restart_bypass", {31'b0, out_data_available}, 32'h1);
        drive(1'b0, '0);
        chk("restart_done", {31'b0, done_pool}, 32'h1);

        // reset during a partial window
        enable_pool = 1'b1; pool_window = 2'd1;
        drive(1'b1, row4(9, 9, 9, 9));
        in_data_available = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_vld", {31'b0, out_data_available}, 32'h0);
        chk("rst_done", {31'b0, done_pool}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(1'b0, '0);
        drive(1'b0, '0);
        chk("post_rst_done", {31'b0, done_pool}, 32'h1);
        chk("post_rst_out", out_data, 32'h0);

        drive(1'b0, '0);
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
